// File: rtl/aes_pkg.sv
// Shared constants, key-size helpers and FSM encoding for the AES key-schedule engine.
package aes_pkg;

    localparam logic [7:0] RCON_INIT = 8'h01;

    // S_REV/S_RDRAIN are reachable only when AES_KS_REVERSE_EN is defined.
    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN,
        S_DRAIN,
        S_REV,
        S_RDRAIN
    } ks_state_e;

    function automatic int nk(input int key_bits);
        return key_bits / 32;
    endfunction

    function automatic int nr(input int key_bits);
        return key_bits / 32 + 6;
    endfunction

    function automatic int nw(input int key_bits);
        return 4 * (key_bits / 32 + 7);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_a,
    output logic [7:0] o_s
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // a^254 == a^-1 for a != 0, and maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    logic [7:0] w_b;

    always_comb begin
        w_b = gf_inv(i_a);
        o_s = w_b ^ {w_b[6:0], w_b[7]} ^ {w_b[5:0], w_b[7:6]}
                  ^ {w_b[4:0], w_b[7:5]} ^ {w_b[3:0], w_b[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES key expansion (128/192/256), one schedule word per clock, round keys streamed
// over valid/ready. Optional macro AES_KS_REVERSE_EN adds a key store for descending-order output.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 256
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [KEY_BITS-1:0] i_key,
    input  logic                i_dec,
    output logic                o_busy,
    output logic [127:0]        o_rk,
    output logic [3:0]          o_rk_idx,
    output logic                o_rk_valid,
    input  logic                i_rk_ready,
    output logic                o_done
);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_key_schedule: KEY_BITS must be 128, 192 or 256");
    end

    localparam int NK = nk(KEY_BITS);
    localparam int NR = nr(KEY_BITS);
    localparam int NW = nw(KEY_BITS);

    ks_state_e    r_state, w_state_nxt;
    logic [31:0]  r_win [NK];
    logic [5:0]   r_cnt;
    logic [2:0]   r_mod;
    logic [7:0]   r_rcon;
    logic [31:0]  r_asm [4];
    logic [1:0]   r_asm_cnt;
    logic         r_asm_full;
    logic [3:0]   r_key_nxt;
    logic [127:0] r_rk;
    logic [3:0]   r_rk_idx;
    logic         r_rk_valid;
    logic         r_done;

    logic         w_rev, w_dec_eff;
    logic [127:0] w_store_rk;
    logic [31:0]  w_prev, w_sub_in, w_sub, w_t, w_word;
    logic         w_out_free, w_prod, w_last, w_asm_mv, w_key_done, w_rev_load, w_fin;

`ifdef AES_KS_REVERSE_EN
    logic        r_rev;
    logic [31:0] r_store [NR+1][4];

    assign w_rev      = r_rev;
    assign w_dec_eff  = i_dec;
    assign w_store_rk = {r_store[r_key_nxt][0], r_store[r_key_nxt][1],
                         r_store[r_key_nxt][2], r_store[r_key_nxt][3]};

    always_ff @(posedge i_clk) begin
        if (i_rst)                            r_rev <= 1'b0;
        else if (r_state == S_IDLE && i_start) r_rev <= i_dec;
    end

    always_ff @(posedge i_clk) begin
        if (w_prod && r_rev) r_store[r_cnt[5:2]][r_cnt[1:0]] <= w_word;
    end
`else
    logic w_unused_dec;

    assign w_rev        = 1'b0;
    assign w_dec_eff    = 1'b0;
    assign w_store_rk   = '0;
    assign w_unused_dec = i_dec;
`endif

    // Schedule word datapath: window holds w[i-NK..i-1]; during the first NK cycles it rotates the key.
    assign w_prev   = r_win[NK-1];
    assign w_sub_in = (r_mod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (.i_a(w_sub_in[8*g +: 8]), .o_s(w_sub[8*g +: 8]));
    end

    always_comb begin
        w_t = w_prev;
        if (r_mod == 3'd0)                 w_t = w_sub ^ {r_rcon, 24'h0};
        else if (NK == 8 && r_mod == 3'd4) w_t = w_sub;
        w_word = (r_cnt < 6'(NK)) ? r_win[0] : (r_win[0] ^ w_t);
    end

    // Handshake: a completed key bypasses into the output register when it is free.
    assign w_out_free = !r_rk_valid || i_rk_ready;
    assign w_prod     = (r_state == S_GEN) && (w_rev || !r_asm_full || w_out_free);
    assign w_last     = w_prod && (r_cnt == 6'(NW-1));
    assign w_asm_mv   = !w_rev && r_asm_full && w_out_free;
    assign w_key_done = w_prod && !w_rev && (r_asm_cnt == 2'd3);
    assign w_rev_load = (r_state == S_REV) && w_out_free;
    assign w_fin      = r_rk_valid && i_rk_ready &&
                        ((r_state == S_DRAIN && r_rk_idx == 4'(NR)) || r_state == S_RDRAIN);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_state_nxt = S_GEN;
            S_GEN:    if (w_last) w_state_nxt = w_rev ? S_REV : S_DRAIN;
            S_DRAIN:  if (w_fin) w_state_nxt = S_IDLE;
            S_REV:    if (w_rev_load && r_key_nxt == 4'd0) w_state_nxt = S_RDRAIN;
            S_RDRAIN: if (w_fin) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_mod      <= '0;
            r_rcon     <= '0;
            r_asm_cnt  <= '0;
            r_asm_full <= 1'b0;
            r_key_nxt  <= '0;
            r_rk       <= '0;
            r_rk_idx   <= '0;
            r_rk_valid <= 1'b0;
            r_done     <= 1'b0;
            for (int k = 0; k < NK; k++) r_win[k] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_fin;

            if (r_state == S_IDLE && i_start) begin
                for (int k = 0; k < NK; k++) r_win[k] <= i_key[KEY_BITS-1-32*k -: 32];
                r_cnt      <= '0;
                r_mod      <= '0;
                r_rcon     <= RCON_INIT;
                r_asm_cnt  <= '0;
                r_asm_full <= 1'b0;
                r_key_nxt  <= w_dec_eff ? 4'(NR) : 4'd0;
            end

            if (w_prod) begin
                for (int k = 0; k < NK-1; k++) r_win[k] <= r_win[k+1];
                r_win[NK-1] <= w_word;
                r_cnt       <= r_cnt + 6'd1;
                r_mod       <= (r_mod == 3'(NK-1)) ? 3'd0 : r_mod + 3'd1;
                if (r_cnt >= 6'(NK) && r_mod == 3'd0) r_rcon <= xtime(r_rcon);
            end
            if (w_prod && !w_rev) r_asm_cnt <= r_asm_cnt + 2'd1;

            if (w_asm_mv)                       r_asm_full <= 1'b0;
            else if (w_key_done && !w_out_free) r_asm_full <= 1'b1;

            if (w_asm_mv || (w_key_done && w_out_free)) begin
                r_rk       <= w_asm_mv ? {r_asm[0], r_asm[1], r_asm[2], r_asm[3]}
                                       : {r_asm[0], r_asm[1], r_asm[2], w_word};
                r_rk_idx   <= r_key_nxt;
                r_rk_valid <= 1'b1;
                r_key_nxt  <= r_key_nxt + 4'd1;
            end else if (w_rev_load) begin
                r_rk       <= w_store_rk;
                r_rk_idx   <= r_key_nxt;
                r_rk_valid <= 1'b1;
                r_key_nxt  <= r_key_nxt - 4'd1;
            end else if (i_rk_ready) begin
                r_rk_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_prod && !w_rev) r_asm[r_asm_cnt] <= w_word;
    end

    assign o_busy     = (r_state != S_IDLE);
    assign o_rk       = r_rk;
    assign o_rk_idx   = r_rk_idx;
    assign o_rk_valid = r_rk_valid;
    assign o_done     = r_done;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule: 128/192/256 instances, FIPS-197 vectors, backpressure, reset.
module tb_aes_key_schedule;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         dec = 1'b0;
    logic         ready = 1'b1;
    logic [255:0] key = '0;
    int           sel = 0;
    int           n_vec = 0;
    int           n_err = 0;

    logic         busy_a, busy_b, busy_c, vld_a, vld_b, vld_c, done_a, done_b, done_c;
    logic [127:0] rk_a, rk_b, rk_c;
    logic [3:0]   idx_a, idx_b, idx_c;
    logic         obs_busy, obs_valid, obs_done;
    logic [127:0] obs_rk;
    logic [3:0]   obs_idx;

    always #5 clk = ~clk;

    aes_key_schedule #(.KEY_BITS(128)) dut128 (
        .i_clk(clk), .i_rst(rst), .i_start(start && sel == 0), .i_key(key[255:128]),
        .i_dec(dec), .o_busy(busy_a), .o_rk(rk_a), .o_rk_idx(idx_a), .o_rk_valid(vld_a),
        .i_rk_ready(ready), .o_done(done_a));

    aes_key_schedule #(.KEY_BITS(192)) dut192 (
        .i_clk(clk), .i_rst(rst), .i_start(start && sel == 1), .i_key(key[255:64]),
        .i_dec(dec), .o_busy(busy_b), .o_rk(rk_b), .o_rk_idx(idx_b), .o_rk_valid(vld_b),
        .i_rk_ready(ready), .o_done(done_b));

    aes_key_schedule #(.KEY_BITS(256)) dut256 (
        .i_clk(clk), .i_rst(rst), .i_start(start && sel == 2), .i_key(key),
        .i_dec(dec), .o_busy(busy_c), .o_rk(rk_c), .o_rk_idx(idx_c), .o_rk_valid(vld_c),
        .i_rk_ready(ready), .o_done(done_c));

    always_comb begin
        obs_busy = busy_a; obs_valid = vld_a; obs_done = done_a; obs_rk = rk_a; obs_idx = idx_a;
        if (sel == 1) begin
            obs_busy = busy_b; obs_valid = vld_b; obs_done = done_b; obs_rk = rk_b; obs_idx = idx_b;
        end else if (sel == 2) begin
            obs_busy = busy_c; obs_valid = vld_c; obs_done = done_c; obs_rk = rk_c; obs_idx = idx_c;
        end
    end

    localparam logic [127:0] K1    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K1_R1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] K1_RL = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] K2    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K2_RL = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K3_RL = 128'ha4970a331a78dc09c418c271e3a41d5d;
    localparam logic [127:0] K4_RL = 128'h24fc79ccbf0979e9371ac23c6d68de36;

    task automatic chk(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        n_vec++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  obs_busy,  1'b0);
        chk({tag, "_valid"}, obs_valid, 1'b0);
        chk({tag, "_rk"},    obs_rk,    '0);
        chk({tag, "_idx"},   obs_idx,   4'd0);
        chk({tag, "_done"},  obs_done,  1'b0);
    endtask

    // mode 0: ready held 1; mode 1: ready toggles 1010..; mode 2: ready 0 for 20 cycles after first valid
    task automatic run(input int s, input logic [255:0] k, input int mode, input logic d,
                       input logic rev, input int nr, input logic [127:0] e_first,
                       input logic [127:0] e_last, input logic [127:0] e_1, input logic t_chk);
        int cyc, nacc, exp_idx, hold, t_done, t_exp, last_idx;
        sel = s; key = k; dec = d; ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; key = ~k; cyc = 0;
        chk("busy_c0", obs_busy, 1'b1);
        nacc = 0; hold = 0; t_done = -1;
        exp_idx  = rev ? nr : 0;
        last_idx = rev ? 0 : nr;
        while (cyc < 400) begin
            if (obs_done) begin
                t_done = cyc;
                start  = 1'b0;
                break;
            end
            start = (cyc == 6);
            if (mode == 2) begin
                if ((obs_valid || hold > 0) && hold < 20) begin
                    ready = 1'b0;
                    hold++;
                    chk("hold_rk", obs_rk, e_first);
                    chk("hold_busy", obs_busy, 1'b1);
                end else begin
                    ready = 1'b1;
                end
            end else if (mode == 1) begin
                ready = (cyc % 2 == 0);
            end else begin
                ready = 1'b1;
            end
            if (obs_valid && ready) begin
                chk("rk_idx_order", obs_idx, exp_idx[3:0]);
                if (exp_idx == 0) chk("rk_first_key", obs_rk, e_first);
                if (exp_idx == nr) chk("rk_last_key", obs_rk, e_last);
                if (s == 0 && exp_idx == 1) chk("rk_round1", obs_rk, e_1);
                if (t_chk) begin
                    t_exp = rev ? (4 * (nr + 1) + 1 + (nr - exp_idx)) : (4 * exp_idx + 4);
                    chk("rk_cycle", cyc, t_exp);
                end
                if (exp_idx == last_idx) start = 1'b1;
                exp_idx = rev ? exp_idx - 1 : exp_idx + 1;
                nacc++;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        ready = 1'b1;
        chk("done_seen", t_done >= 0, 1'b1);
        chk("key_count", nacc, nr + 1);
        if (t_chk) chk("done_cycle", t_done, rev ? (5 * nr + 6) : (4 * nr + 5));
        @(negedge clk);
        chk("post_busy", obs_busy, 1'b0);
        chk("post_done", obs_done, 1'b0);
        chk("post_valid", obs_valid, 1'b0);
    endtask

    initial begin
        sel = 0;
        repeat (2) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;

        run(0, {K1, 128'h0}, 0, 1'b0, 1'b0, 10, K1, K1_RL, K1_R1, 1'b1);
        run(0, {K2, 128'h0}, 1, 1'b0, 1'b0, 10, K2, K2_RL, K2_R1, 1'b0);
        run(1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 0, 1'b0, 1'b0,
            12, K1, K3_RL, 128'h0, 1'b1);
        run(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 0,
            1'b0, 1'b0, 14, K1, K4_RL, 128'h0, 1'b1);
        run(0, {K1, 128'h0}, 2, 1'b0, 1'b0, 10, K1, K1_RL, K1_R1, 1'b0);

        sel = 0; key = {K1, 128'h0}; dec = 1'b0; ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle("midrst");
        run(0, {K2, 128'h0}, 0, 1'b0, 1'b0, 10, K2, K2_RL, K2_R1, 1'b1);

`ifdef AES_KS_REVERSE_EN
        run(0, {K1, 128'h0}, 0, 1'b1, 1'b1, 10, K1, K1_RL, K1_R1, 1'b1);
`else
        run(0, {K1, 128'h0}, 0, 1'b1, 1'b0, 10, K1, K1_RL, K1_R1, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
